spi_master_tx: RTL

- Transmit datapath of the SPI master, directly downstream of the SPI clock generator.
- Takes 32-bit words from the controller/FIFO over a valid/ready handshake and shifts them MSB-first onto sdo0 (single mode) or sdo3..sdo0 (quad mode).
- Advances one unit on each clock-generator fall strobe.
- Drives the clock generator's enable, parking SCLK whenever no data is available, and pulses tx_done at the end of the transfer.

---
 rtl/spi_master_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spi_master_tx.sv
// SPI master transmit datapath: shifts 32-bit words MSB-first onto sdo0 (single)
// or sdo3..sdo0 (quad), advancing on each clock-generator fall strobe.
module spi_master_tx #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tx_edge,
    input  logic             en_quad_in,
    input  logic [CNT_W-1:0] counter_in,
    input  logic             counter_in_upd,
    input  logic [31:0]      data,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             clk_en_o,
    output logic             tx_done,
    output logic             sdo0,
    output logic             sdo1,
    output logic             sdo2,
    output logic             sdo3
);

    typedef enum logic [1:0] {
        IDLE,
        TRANSMIT,
        WAIT_DATA
    } state_t;

    state_t           state, state_next;
    logic [31:0]      sr, sr_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] len, len_next;
    logic             quad, quad_next;
    logic             done, done_next;

    logic [CNT_W-1:0] units_start;
    logic [CNT_W-1:0] units_run;
    logic             last_unit;
    logic             word_end;

    // Start-of-transfer decision uses the incoming mode; the running transfer
    // uses the mode latched at its start.
    assign units_start = en_quad_in ? (len >> 2) : len;
    assign units_run   = quad ? (len >> 2) : len;
    assign last_unit   = (cnt == units_run - CNT_W'(1));
    assign word_end    = quad ? (cnt[2:0] == 3'd7) : (cnt[4:0] == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            len   <= CNT_W'(8);
            quad  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
            len   <= len_next;
            quad  <= quad_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        len_next   = len;
        quad_next  = quad;
        done_next  = 1'b0;
        data_ready = 1'b0;
        clk_en_o   = 1'b0;

        case (state)
            IDLE: begin
                data_ready = en;
                if (counter_in_upd) begin
                    len_next = counter_in;
                end
                if (en && data_valid) begin
                    sr_next   = data;
                    cnt_next  = '0;
                    quad_next = en_quad_in;
                    if (units_start == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = TRANSMIT;
                    end
                end
            end

            TRANSMIT: begin
                clk_en_o = 1'b1;
                if (tx_edge) begin
                    if (last_unit) begin
                        done_next  = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else if (word_end) begin
                        // Refill at the word boundary instead of shifting; park SCLK if starved.
                        data_ready = 1'b1;
                        cnt_next   = cnt + CNT_W'(1);
                        if (data_valid) begin
                            sr_next = data;
                        end else begin
                            state_next = WAIT_DATA;
                        end
                    end else begin
                        sr_next  = quad ? {sr[27:0], 4'b0000} : {sr[30:0], 1'b0};
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end

            WAIT_DATA: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    sr_next    = data;
                    state_next = TRANSMIT;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_done = done;
    assign sdo3    = quad & sr[31];
    assign sdo2    = quad & sr[30];
    assign sdo1    = quad & sr[29];
    assign sdo0    = quad ? sr[28] : sr[31];

endmodule
